// File: rtl/evo_circuit_prober_pkg.sv
// Shared types for the evolved-circuit prober: FSM states, result class codes
// and the classification rule applied to each sampling window.
package evo_test_pkg;

   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, REPORT, DONE} state_t;

   typedef logic [1:0] cls_t;

   localparam cls_t CLS_LOW  = 2'd0;
   localparam cls_t CLS_HIGH = 2'd1;
   localparam cls_t CLS_LATE = 2'd2;
   localparam cls_t CLS_OSC  = 2'd3;

   // Zero toggles means the window was constant, so ones is either 0 or the full window.
   function automatic cls_t classify(input int ones, input int tog, input int window);
      if (tog >= 2)           return CLS_OSC;
      else if (tog == 1)      return CLS_LATE;
      else if (ones == window) return CLS_HIGH;
      else                    return CLS_LOW;
   endfunction

endpackage

// File: rtl/evo_circuit_prober_if.sv
// Controller-side bus of the prober: start/abort control, status and the
// valid/ready result channel.
interface evo_circuit_prober_if #(
   parameter int IN_WIDTH = 2,
   parameter int CNT_W    = 9
);
   logic                   start;
   logic                   abort;
   logic                   busy;
   logic                   done;
   logic                   res_valid;
   logic                   res_ready;
   logic [IN_WIDTH-1:0]    res_vector;
   logic [CNT_W-1:0]       res_ones;
   logic [CNT_W-1:0]       res_toggles;
   evo_test_pkg::cls_t     res_class;

   modport master (
      output start, abort, res_ready,
      input  busy, done, res_valid, res_vector, res_ones, res_toggles, res_class
   );

   modport slave (
      input  start, abort, res_ready,
      output busy, done, res_valid, res_vector, res_ones, res_toggles, res_class
   );
endinterface

// File: rtl/evo_circuit_prober_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) {q, meta} <= 2'b00;
      else        {q, meta} <= {meta, d};
   end
endmodule

// File: rtl/evo_circuit_prober.sv
// Sweeps every input vector into an evolved circuit, samples its synchronized
// output over a fixed window and reports ones/toggle counts plus a class.
module evo_circuit_prober
   import evo_test_pkg::*;
#(
   parameter int IN_WIDTH      = 2,
   parameter int SETTLE_CYCLES = 16,
   parameter int WINDOW_CYCLES = 256,
   parameter int CNT_W         = $clog2(WINDOW_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   evo_circuit_prober_if.slave bus,
   output logic [IN_WIDTH-1:0] dut_in,
   input  logic                dut_out
);
   localparam int PH_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX);
   localparam logic [PH_W-1:0]     SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0]     WIN_LAST    = PH_W'(WINDOW_CYCLES - 1);
   localparam logic [IN_WIDTH-1:0] VEC_LAST    = '1;

   state_t              state, nstate;
   logic [PH_W-1:0]     ph_cnt;
   logic [CNT_W-1:0]    ones_q, tog_q, ones_n, tog_n;
   logic                prev_q, s, hs;
   logic [IN_WIDTH-1:0] r_vec;
   logic [CNT_W-1:0]    r_ones, r_tog;
   cls_t                r_cls;

   sync_2ff u_sync (.clk, .rst_n, .d(dut_out), .q(s));

   assign hs = (state == REPORT) && bus.res_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (bus.start) nstate = SETTLE;
         SETTLE:  if (ph_cnt == SETTLE_LAST) nstate = SAMPLE;
         SAMPLE:  if (ph_cnt == WIN_LAST) nstate = REPORT;
         REPORT:  if (hs) nstate = (dut_in == VEC_LAST) ? DONE : SETTLE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
      // abort beats both a pending handshake and the sweep end
      if (bus.abort && state != IDLE) nstate = IDLE;
   end

   always_comb begin
      bus.busy        = (state != IDLE);
      bus.done        = (state == DONE);
      bus.res_valid   = (state == REPORT);
      bus.res_vector  = r_vec;
      bus.res_ones    = r_ones;
      bus.res_toggles = r_tog;
      bus.res_class   = r_cls;
   end

   // First sample of a window has no predecessor, so it never counts as a toggle.
   always_comb begin
      ones_n = ones_q + CNT_W'(s);
      tog_n  = tog_q + CNT_W'((ph_cnt != '0) && (s != prev_q));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ph_cnt <= '0;
         ones_q <= '0;
         tog_q  <= '0;
         prev_q <= 1'b0;
         dut_in <= '0;
         r_vec  <= '0;
         r_ones <= '0;
         r_tog  <= '0;
         r_cls  <= CLS_LOW;
      end else begin
         if (state != nstate)                        ph_cnt <= '0;
         else if (state == SETTLE || state == SAMPLE) ph_cnt <= ph_cnt + 1'b1;

         if (state == SETTLE) begin
            ones_q <= '0;
            tog_q  <= '0;
         end else if (state == SAMPLE) begin
            ones_q <= ones_n;
            tog_q  <= tog_n;
            prev_q <= s;
         end

         if (state == SAMPLE && ph_cnt == WIN_LAST) begin
            r_vec  <= dut_in;
            r_ones <= ones_n;
            r_tog  <= tog_n;
            r_cls  <= classify(int'(ones_n), int'(tog_n), WINDOW_CYCLES);
         end

         if (nstate == IDLE)                          dut_in <= '0;
         else if (state == REPORT && nstate == SETTLE) dut_in <= dut_in + 1'b1;
      end
   end
endmodule
